// File: rtl/uartlite_pkg.sv
// uartlite_pkg: register offsets, response codes and STAT/CTRL bit layout for the UART-Lite responder
package uartlite_pkg;
  localparam logic [1:0] OFF_RX = 2'd0;
  localparam logic [1:0] OFF_TX = 2'd1;
  localparam logic [1:0] OFF_STAT = 2'd2;
  localparam logic [1:0] OFF_CTRL = 2'd3;
  localparam logic [1:0] RESP_OKAY = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam int STAT_RX_VALID = 0;
  localparam int STAT_RX_FULL = 1;
  localparam int STAT_TX_EMPTY = 2;
  localparam int STAT_TX_FULL = 3;
  localparam int STAT_IEN = 4;
  localparam int STAT_OVERRUN = 5;
  localparam int CTRL_TX_FLUSH = 0;
  localparam int CTRL_RX_FLUSH = 1;
  localparam int CTRL_IEN = 4;
  function automatic logic [31:0] stat_word(input logic rx_ne, rx_full, tx_empty, tx_full, ien, ovr);
    logic [31:0] s;
    s = '0;
    s[STAT_RX_VALID] = rx_ne;
    s[STAT_RX_FULL] = rx_full;
    s[STAT_TX_EMPTY] = tx_empty;
    s[STAT_TX_FULL] = tx_full;
    s[STAT_IEN] = ien;
    s[STAT_OVERRUN] = ovr;
    return s;
  endfunction
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with flush; pointers carry an extra wrap bit
//   clk, rst (async active-low); push/din write, pop consumes head, flush empties
//   full/empty flags; head is the oldest entry, 0 while empty
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic do_push, do_pop;
  assign empty = wr_ptr == rd_ptr;
  assign full = wr_ptr == {~rd_ptr[AW], rd_ptr[AW-1:0]};
  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  assign head = empty ? '0 : mem[rd_ptr[AW-1:0]];
  // flush wins over any push/pop in the same cycle
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      wr_ptr <= flush ? '0 : wr_ptr + {{AW{1'b0}}, do_push};
      rd_ptr <= flush ? '0 : rd_ptr + {{AW{1'b0}}, do_pop};
    end
  always_ff @(posedge clk)
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
endmodule

// File: rtl/axi_uartlite_slave.sv
// axi_uartlite_slave: AXI4-Lite responder exposing the UART-Lite RX/TX/STAT/CTRL registers
//   clk, rst (async active-low)
//   s_axi_aw*/w*/b*: write channels; s_axi_ar*/r*: read channels
//   tx_data/tx_valid/tx_ready: outgoing byte stream from the TX FIFO
//   rx_data/rx_valid: incoming byte strobe into the RX FIFO
//   intr: registered level interrupt
module axi_uartlite_slave
  import uartlite_pkg::*;
#(
  parameter int FIFO_DEPTH = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] s_axi_awaddr,
  input  logic        s_axi_awvalid,
  output logic        s_axi_awready,
  input  logic [31:0] s_axi_wdata,
  input  logic [3:0]  s_axi_wstrb,
  input  logic        s_axi_wvalid,
  output logic        s_axi_wready,
  output logic [1:0]  s_axi_bresp,
  output logic        s_axi_bvalid,
  input  logic        s_axi_bready,
  input  logic [31:0] s_axi_araddr,
  input  logic        s_axi_arvalid,
  output logic        s_axi_arready,
  output logic [31:0] s_axi_rdata,
  output logic [1:0]  s_axi_rresp,
  output logic        s_axi_rvalid,
  input  logic        s_axi_rready,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        intr
);
  logic live, aw_held, w_held, intr_en, overrun;
  logic [1:0] aw_off, ar_off, wr_resp, rd_resp;
  logic [7:0] w_byte, rx_head;
  logic [31:0] rd_val;
  logic aw_hs, w_hs, ar_hs, do_wr, ctrl_wr;
  logic tx_push, tx_pop, tx_flush, tx_full, tx_empty;
  logic rx_pop, rx_flush, rx_full, rx_empty, stat_rd, ovr_set;
  logic unused_bits;
  assign unused_bits = ^{s_axi_wstrb, s_axi_wdata[31:8], s_axi_awaddr[31:4], s_axi_awaddr[1:0],
                         s_axi_araddr[31:4], s_axi_araddr[1:0]};
  // live holds readies low until the first edge after reset release
  assign s_axi_awready = live && !aw_held && !s_axi_bvalid;
  assign s_axi_wready = live && !w_held && !s_axi_bvalid;
  assign s_axi_arready = live && !s_axi_rvalid;
  assign tx_valid = !tx_empty;
  assign ar_off = s_axi_araddr[3:2];
  always_comb begin
    aw_hs = s_axi_awvalid && s_axi_awready;
    w_hs = s_axi_wvalid && s_axi_wready;
    ar_hs = s_axi_arvalid && s_axi_arready;
    do_wr = aw_held && w_held;
    ctrl_wr = do_wr && aw_off == OFF_CTRL;
    tx_push = do_wr && aw_off == OFF_TX;
    tx_pop = tx_valid && tx_ready;
    tx_flush = ctrl_wr && w_byte[CTRL_TX_FLUSH];
    rx_flush = ctrl_wr && w_byte[CTRL_RX_FLUSH];
    rx_pop = ar_hs && ar_off == OFF_RX;
    stat_rd = ar_hs && ar_off == OFF_STAT;
    ovr_set = rx_valid && rx_full;
    wr_resp = (aw_off == OFF_TX && tx_full) ? RESP_SLVERR : RESP_OKAY;
    rd_val = ar_off == OFF_RX ? {24'b0, rx_head} :
             ar_off == OFF_STAT ? stat_word(!rx_empty, rx_full, tx_empty, tx_full, intr_en, overrun) : '0;
    rd_resp = (ar_off == OFF_RX && rx_empty) ? RESP_SLVERR : RESP_OKAY;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      live <= 1'b0;
      aw_held <= 1'b0;
      w_held <= 1'b0;
      aw_off <= '0;
      w_byte <= '0;
      intr_en <= 1'b0;
      overrun <= 1'b0;
      s_axi_bvalid <= 1'b0;
      s_axi_bresp <= RESP_OKAY;
      s_axi_rvalid <= 1'b0;
      s_axi_rdata <= '0;
      s_axi_rresp <= RESP_OKAY;
      intr <= 1'b0;
    end else begin
      live <= 1'b1;
      aw_held <= aw_hs || (aw_held && !do_wr);
      w_held <= w_hs || (w_held && !do_wr);
      aw_off <= aw_hs ? s_axi_awaddr[3:2] : aw_off;
      w_byte <= w_hs ? s_axi_wdata[7:0] : w_byte;
      intr_en <= ctrl_wr ? w_byte[CTRL_IEN] : intr_en;
      overrun <= ovr_set || (overrun && !stat_rd);
      s_axi_bvalid <= do_wr || (s_axi_bvalid && !s_axi_bready);
      s_axi_bresp <= do_wr ? wr_resp : s_axi_bresp;
      s_axi_rvalid <= ar_hs || (s_axi_rvalid && !s_axi_rready);
      s_axi_rdata <= ar_hs ? rd_val : s_axi_rdata;
      s_axi_rresp <= ar_hs ? rd_resp : s_axi_rresp;
      intr <= intr_en && (!rx_empty || tx_empty);
    end
  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx (
    .clk(clk), .rst(rst), .push(tx_push), .pop(tx_pop), .flush(tx_flush),
    .din(w_byte), .full(tx_full), .empty(tx_empty), .head(tx_data)
  );
  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx (
    .clk(clk), .rst(rst), .push(rx_valid), .pop(rx_pop), .flush(rx_flush),
    .din(rx_data), .full(rx_full), .empty(rx_empty), .head(rx_head)
  );
endmodule
